uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It adds a baud-rate divider, a configurable data width, one or two stop bits, a ready/valid input handshake and a done pulse. It sits between a byte source (FIFO or command sequencer) and the FPGA TX pin. It serialises one frame at a time, LSB first, and idles at logic high.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_valid  input  1  source has a word on tx_data.
tx_data  input  DATA_BITS  word to send; sampled only on acceptance.
tx_ready  output  1  block can accept a word (high only in IDLE).
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress (not IDLE).
done  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (synchronous, rst sampled high on clk edge): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, bit counter and baud counter cleared, shift register cleared.
- Reset mid-frame aborts the frame. tx returns to 1 at that same edge; no done pulse is produced.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, tx_ready=1. Acceptance is the edge where tx_valid && tx_ready. At that edge:
  - tx_data is latched into the shift register;
  - state goes to START and tx drives 0;
  - tx_ready drops and busy rises.
- Bit timing: every bit (start, each data bit, parity, each stop bit) holds tx stable for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on terminal count. It is $clog2(CLKS_PER_BIT) bits wide.
- DATA: sends bit 0 first and shifts right each bit period. The bit counter counts 0..DATA_BITS-1. After the last data bit, go to PARITY if enabled, else STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle's edge, state goes to IDLE; done=1 and tx_ready=1 in the following cycle.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles from the acceptance edge to the IDLE edge (P = 1 with parity, else 0).
- Back-to-back: if tx_valid is held high, the next word is accepted on the first IDLE cycle (the done cycle). The gap between the final stop bit and the next start bit is exactly one clk cycle of tx=1.
- tx_data and tx_valid changes while busy are ignored. tx_valid need not be held after acceptance.
- tx is driven from a register (glitch-free). done and tx_ready are registered.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state follows DATA and lasts one bit period. tx = XOR of the latched data bits, XOR PARITY_ODD. Frame grows by one bit period.
- Undefined: no PARITY state and no parity logic. PARITY_ODD is ignored and the frame is DATA_BITS data bits followed by stop bits.

Test Plan:
1. Defaults except CLKS_PER_BIT=4, no parity. Accept 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses exactly 40 cycles after the acceptance edge; tx_ready=0 throughout the frame.
2. tx_valid held high with 0x01 then 0x80 -> second start bit falls exactly 1 cycle after the first frame's last stop cycle. Decoded bytes are 0x01, 0x80, and done pulses twice.
3. STOP_BITS=2, CLKS_PER_BIT=4, send 0x00 -> tx high for 8 cycles after the data; frame is 44 cycles.
4. UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1, send 0x03 -> parity bit 1. Frame is 44 cycles at CLKS_PER_BIT=4.
5. Assert rst during the 3rd data bit -> tx=1, busy=0, tx_ready=1 after that edge, and no done pulse. A new word is accepted normally afterwards.
6. DATA_BITS=5, send 0x1F while tx_data toggles to 0x00 mid-frame -> line carries 11111 and the toggle has no effect.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter. It takes one word at a time from a
// ready/valid source and sends it on the TX pin as a frame: a start bit,
// DATA_BITS data bits LSB first, an optional parity bit, and STOP_BITS stop
// bits. The line idles high. Every bit lasts CLKS_PER_BIT clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit follows the data bits. Its value is the XOR of
//               the data bits, XORed with PARITY_ODD.
//   undefined : no parity state and no parity logic; PARITY_ODD is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    parity sense, 0 = even, 1 = odd
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any frame in progress
//   tx_valid  source has a word on tx_data
//   tx_data   word to send, sampled only on the accepting edge
//   tx_ready  high only in IDLE; a word is taken when tx_valid && tx_ready
//   tx        registered serial output
//   busy      high while a frame is in progress
//   done      one-cycle pulse after the final stop bit completes
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Elaboration-time guards against illegal parameter values.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_next;
    logic                 done_next;
    logic                 ready_next;
    logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_next;
`endif

    // State and output registers. tx, done, tx_ready and busy are all
    // registered so the pin and the handshake never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            done      <= 1'b0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            done      <= done_next;
            tx_ready  <= ready_next;
            busy      <= !ready_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Next-state logic. tx_next is the value the line takes for the bit that
    // starts at the coming edge, so every transition also chooses the level
    // of the next bit.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        tx_next    = tx;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        baud_tick = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                tx_next = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_next = S_START;
                    shift_next = tx_data;
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^tx_data) ^ PARITY_ODD[0];
`endif
                end
            end

            S_START: begin
                if (baud_tick) begin
                    baud_next  = '0;
                    state_next = S_DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            // The current data bit is always shift_reg[0]; the next one is
            // shift_reg[1] until the register is shifted at the same edge.
            S_DATA: begin
                if (baud_tick) begin
                    baud_next = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
`endif

            // bit_cnt is reused to count stop bits.
            S_STOP: begin
                tx_next = 1'b1;
                if (baud_tick) begin
                    baud_next = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        ready_next = (state_next == S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Self-checking bench for uart_tx_frame. Three instances cover the
// parameter corners: A = 8 data / 1 stop / even, B = 8 data / 2 stop / odd,
// C = 5 data / 1 stop / even, all at CLKS_PER_BIT = 4. A select picks which
// instance receives tx_valid and which one is observed.
module tb_uart_tx_frame;

    localparam int CPB  = 4;
    localparam int NVEC = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] sel;

    logic valid_a, ready_a, tx_a, busy_a, done_a;
    logic valid_b, ready_b, tx_b, busy_b, done_b;
    logic valid_c, ready_c, tx_c, busy_c, done_c;
    logic [3:0] obs;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    assign valid_a = tx_valid && (sel == 2'd0);
    assign valid_b = tx_valid && (sel == 2'd1);
    assign valid_c = tx_valid && (sel == 2'd2);

    // Observed outputs of the selected instance: {tx, tx_ready, busy, done}.
    always_comb begin
        case (sel)
            2'd0:    obs = {tx_a, ready_a, busy_a, done_a};
            2'd1:    obs = {tx_b, ready_b, busy_b, done_b};
            default: obs = {tx_c, ready_c, busy_c, done_c};
        endcase
    end

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(valid_a), .tx_data(tx_data),
        .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(valid_b), .tx_data(tx_data),
        .tx_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) dut_c (
        .clk(clk), .rst(rst), .tx_valid(valid_c), .tx_data(tx_data[4:0]),
        .tx_ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  data;
        bit          hold;
        logic [12:0] pattern;
        int          nbits;
    } vec_t;

    vec_t vec [NVEC];

    function automatic int dataBits(input logic [1:0] s);
        return (s == 2'd2) ? 5 : 8;
    endfunction

    function automatic int stopBits(input logic [1:0] s);
        return (s == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit parityOdd(input logic [1:0] s);
        return (s == 2'd1);
    endfunction

    // Reference line: list of bit levels, index 0 = start bit.
    task automatic modelLine(input logic [1:0] s, input logic [7:0] word,
                             output logic [12:0] pattern, output int nbits);
        int pos;
        int ones;
        pattern = '0;
        pos = 0;
        ones = 0;
        pattern[pos] = 1'b0;
        pos++;
        for (int i = 0; i < dataBits(s); i++) begin
            pattern[pos] = word[i];
            ones += int'(word[i]);
            pos++;
        end
`ifdef UART_TX_PARITY_EN
        pattern[pos] = ((ones % 2) != 0) ^ parityOdd(s);
        pos++;
`endif
        for (int i = 0; i < stopBits(s); i++) begin
            pattern[pos] = 1'b1;
            pos++;
        end
        nbits = pos;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // Offer a word to instance s from idle; returns at the first negedge
    // after the accepting edge.
    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] word);
        int n;
        sel      = s;
        tx_data  = word;
        tx_valid = 1'b1;
        n = 0;
        while (obs[2] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait tx_ready", {31'b0, obs[2]}, 32'd1);
        @(negedge clk);
    endtask

    // Called at the first negedge after acceptance. Checks every cycle of
    // the frame while scrambling tx_data, then checks the done cycle.
    task automatic checkFrame(input logic [12:0] pattern, input int nbits,
                              input bit keep_valid, input string tag);
        for (int k = 0; k < nbits * CPB; k++) begin
            if (k == 0 && !keep_valid) tx_valid = 1'b0;
            checkOutput({tag, " line"}, {28'b0, obs}, {28'b0, pattern[k / CPB], 3'b010});
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        checkOutput({tag, " done"}, {28'b0, obs}, 32'hD);
    endtask

    initial begin
        logic [12:0] pat;
        int          nb;
        int          seen;
        bit          prev_hold;
        logic [1:0]  s;
        logic [7:0]  w;

`ifdef UART_TX_PARITY_EN
        vec[0] = '{2'd0, 8'hA5, 1'b0, 13'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
        vec[1] = '{2'd0, 8'h01, 1'b1, 13'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
        vec[2] = '{2'd0, 8'h80, 1'b0, 13'({1'b1, 1'b1, 8'h80, 1'b0}), 11};
        vec[3] = '{2'd1, 8'h00, 1'b0, 13'({2'b11, 1'b1, 8'h00, 1'b0}), 12};
        vec[4] = '{2'd2, 8'h1F, 1'b0, 13'({1'b1, 1'b1, 5'h1F, 1'b0}), 8};
        vec[5] = '{2'd0, 8'h07, 1'b0, 13'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
        vec[6] = '{2'd1, 8'h03, 1'b0, 13'({2'b11, 1'b1, 8'h03, 1'b0}), 12};
`else
        vec[0] = '{2'd0, 8'hA5, 1'b0, 13'({1'b1, 8'hA5, 1'b0}), 10};
        vec[1] = '{2'd0, 8'h01, 1'b1, 13'({1'b1, 8'h01, 1'b0}), 10};
        vec[2] = '{2'd0, 8'h80, 1'b0, 13'({1'b1, 8'h80, 1'b0}), 10};
        vec[3] = '{2'd1, 8'h00, 1'b0, 13'({2'b11, 8'h00, 1'b0}), 11};
        vec[4] = '{2'd2, 8'h1F, 1'b0, 13'({1'b1, 5'h1F, 1'b0}), 7};
        vec[5] = '{2'd0, 8'h07, 1'b0, 13'({1'b1, 8'h07, 1'b0}), 10};
        vec[6] = '{2'd1, 8'h03, 1'b0, 13'({2'b11, 8'h03, 1'b0}), 11};
`endif

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel      = 2'd0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            checkOutput($sformatf("reset state inst%0d", i), {28'b0, obs}, 32'hC);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        prev_hold = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (prev_hold) begin
                tx_data = vec[i].data;
                @(negedge clk);
            end else begin
                applyStimulus(vec[i].sel, vec[i].data);
            end
            checkFrame(vec[i].pattern, vec[i].nbits, vec[i].hold, $sformatf("vec%0d", i));
            if (!vec[i].hold) begin
                @(negedge clk);
                checkOutput($sformatf("vec%0d after done", i), {28'b0, obs}, 32'hC);
            end
            prev_hold = vec[i].hold;
        end

        $display("[TB] reset during third data bit");
        applyStimulus(2'd0, 8'h5A);
        tx_valid = 1'b0;
        repeat (13) @(negedge clk);
        checkOutput("pre-reset data bit 2", {28'b0, obs}, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort by reset", {28'b0, obs}, 32'hC);
        rst = 1'b0;
        seen = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (obs !== 4'hC) seen++;
        end
        checkOutput("idle after abort", seen, 0);
        applyStimulus(2'd0, 8'h3C);
        modelLine(2'd0, 8'h3C, pat, nb);
        checkFrame(pat, nb, 1'b0, "post-reset");
        @(negedge clk);

        $display("[TB] random frames");
        repeat (30) begin
            s = 2'($urandom_range(0, 2));
            w = 8'($urandom);
            applyStimulus(s, w);
            modelLine(s, w, pat, nb);
            checkFrame(pat, nb, 1'b0, $sformatf("rand inst%0d data %02h", s, w));
            @(negedge clk);
            checkOutput("rand after done", {28'b0, obs}, 32'hC);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
